// File: rtl/ring_link_arbiter_if.sv
// Handshake bundle for one ring_link_arbiter: forward source, local source and outgoing link.
// Signal names are from the arbiter's side; the slave modport is the arbiter, master the environment.
interface ring_link_arbiter_if #(
    parameter int DataWidth = 64
);
    logic [DataWidth-1:0] fwd_data_i;
    logic                 fwd_valid_i;
    logic                 fwd_ready_o;
    logic [DataWidth-1:0] loc_data_i;
    logic                 loc_valid_i;
    logic                 loc_ready_o;
    logic [DataWidth-1:0] link_data_o;
    logic                 link_valid_o;
    logic                 link_ready_i;

    modport slave (
        input  fwd_data_i, fwd_valid_i,
        output fwd_ready_o,
        input  loc_data_i, loc_valid_i,
        output loc_ready_o,
        output link_data_o, link_valid_o,
        input  link_ready_i
    );

    modport master (
        output fwd_data_i, fwd_valid_i,
        input  fwd_ready_o,
        output loc_data_i, loc_valid_i,
        input  loc_ready_o,
        input  link_data_o, link_valid_o,
        output link_ready_i
    );
endinterface

// File: rtl/ring_link_arbiter.sv
// Shares one outgoing ring link between forward and local traffic; forward wins, MaxBurst bounds each tenure.
// Define RING_LINK_ARB_STATS_EN to build the beat and stall counters; otherwise those outputs are tied to 0.
module ring_link_arbiter #(
    parameter int DataWidth = 64,
    parameter int MaxBurst  = 4,
    parameter int FifoDepth = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    ring_link_arbiter_if.slave link_if,
    output logic [1:0]         grant_o,
    output logic [31:0]        fwd_beats_o,
    output logic [31:0]        loc_beats_o,
    output logic [31:0]        stall_cycles_o
);
    localparam int PtrW   = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntW   = $clog2(FifoDepth + 1);
    localparam int BurstW = $clog2(MaxBurst + 1);

    // Encoding doubles as the grant_o value.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FWD  = 2'b01,
        ST_LOC  = 2'b10
    } state_e;

    state_e               state_q, state_d;
    logic [BurstW-1:0]    burst_q, burst_d, burst_inc;
    logic [DataWidth-1:0] mem_q [FifoDepth];
    logic [PtrW-1:0]      wptr_q, rptr_q;
    logic [CntW-1:0]      count_q, count_d;
    logic                 full, empty;
    logic                 fwd_acc, loc_acc, push, pop;
    logic [DataWidth-1:0] push_data;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CntW'(FifoDepth));
    assign empty = (count_q == '0);

    assign link_if.fwd_ready_o  = (state_q == ST_FWD) && !full;
    assign link_if.loc_ready_o  = (state_q == ST_LOC) && !full;
    assign link_if.link_valid_o = !empty;
    assign link_if.link_data_o  = empty ? '0 : mem_q[rptr_q];
    assign grant_o              = state_q;

    assign fwd_acc   = link_if.fwd_valid_i && link_if.fwd_ready_o;
    assign loc_acc   = link_if.loc_valid_i && link_if.loc_ready_o;
    assign push      = fwd_acc || loc_acc;
    assign pop       = !empty && link_if.link_ready_i;
    assign push_data = fwd_acc ? link_if.fwd_data_i : link_if.loc_data_i;

    // NOTE: every signal assigned in a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        burst_inc = burst_q;
        if (push && burst_q != BurstW'(MaxBurst)) begin
            burst_inc = burst_q + 1'b1;
        end
        // The burst limit looks at the count including this cycle's beat, so the switch lands without an extra beat.
        case (state_q)
            ST_IDLE: begin
                if (link_if.fwd_valid_i)      state_d = ST_FWD;
                else if (link_if.loc_valid_i) state_d = ST_LOC;
            end
            ST_FWD: begin
                if (!link_if.fwd_valid_i) begin
                    state_d = link_if.loc_valid_i ? ST_LOC : ST_IDLE;
                end else if (link_if.loc_valid_i && burst_inc == BurstW'(MaxBurst)) begin
                    state_d = ST_LOC;
                end
            end
            ST_LOC: begin
                if (!link_if.loc_valid_i) begin
                    state_d = link_if.fwd_valid_i ? ST_FWD : ST_IDLE;
                end else if (link_if.fwd_valid_i && burst_inc == BurstW'(MaxBurst)) begin
                    state_d = ST_FWD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        burst_d = (state_d != state_q) ? '0 : burst_inc;
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            burst_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            count_q <= count_d;
            if (push) wptr_q <= ptr_next(wptr_q);
            if (pop)  rptr_q <= ptr_next(rptr_q);
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the head is masked while empty so stale data never escapes.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= push_data;
    end

`ifdef RING_LINK_ARB_STATS_EN
    logic [31:0] fwd_beats_q, loc_beats_q, stall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fwd_beats_q <= '0;
            loc_beats_q <= '0;
            stall_q     <= '0;
        end else begin
            if (fwd_acc && fwd_beats_q != '1) fwd_beats_q <= fwd_beats_q + 1'b1;
            if (loc_acc && loc_beats_q != '1) loc_beats_q <= loc_beats_q + 1'b1;
            if (!empty && !link_if.link_ready_i && stall_q != '1) stall_q <= stall_q + 1'b1;
        end
    end

    assign fwd_beats_o    = fwd_beats_q;
    assign loc_beats_o    = loc_beats_q;
    assign stall_cycles_o = stall_q;
`else
    assign fwd_beats_o    = '0;
    assign loc_beats_o    = '0;
    assign stall_cycles_o = '0;
`endif
endmodule

// File: tb/tb_ring_link_arbiter.sv
// Directed and random traffic against a queue-based model of the ring link arbiter.
// Honours RING_LINK_ARB_STATS_EN to decide what the statistics outputs must read.
module tb_ring_link_arbiter;
    localparam int         DW    = 64;
    localparam int         MB    = 4;
    localparam int         DEPTH = 2;
    localparam logic [7:0] TAG_F = 8'hF0;
    localparam logic [7:0] TAG_L = 8'hA0;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  grant_o;
    logic [31:0] fwd_beats_o, loc_beats_o, stall_cycles_o;

    ring_link_arbiter_if #(.DataWidth(DW)) link ();

    ring_link_arbiter #(.DataWidth(DW), .MaxBurst(MB), .FifoDepth(DEPTH)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .link_if        (link.slave),
        .grant_o        (grant_o),
        .fwd_beats_o    (fwd_beats_o),
        .loc_beats_o    (loc_beats_o),
        .stall_cycles_o (stall_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    logic [63:0] fwd_q[$], loc_q[$], sb_q[$], popped_q[$];
    logic [1:0]  g_log[$];
    logic        v_log[$];
    int          f_pct, l_pct, r_pct;
    int          cnt_m, mf, ml, ms, w_fwd, w_loc;
    logic        f_acc, l_acc, pop_s;
    logic        s_valid, s_fwd_ready;
    logic [63:0] s_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_i             = 1'b1;
        link.fwd_valid_i  = 1'b0;
        link.loc_valid_i  = 1'b0;
        link.fwd_data_i   = '0;
        link.loc_data_i   = '0;
        link.link_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        fwd_q.delete(); loc_q.delete(); sb_q.delete(); popped_q.delete();
        g_log.delete(); v_log.delete();
        cnt_m = 0; mf = 0; ml = 0; ms = 0; w_fwd = 0; w_loc = 0;
        f_acc = 1'b0; l_acc = 1'b0;
        f_pct = 100; l_pct = 100; r_pct = 100;
    endtask

    // One clock: drive sources and link, sample at the falling edge, update the model.
    task automatic cycle();
        logic [63:0] exp_head;
        if (f_acc) link.fwd_valid_i = 1'b0;
        if (l_acc) link.loc_valid_i = 1'b0;
        if (!link.fwd_valid_i && fwd_q.size() > 0 && $urandom_range(99) < f_pct) begin
            link.fwd_valid_i = 1'b1;
            link.fwd_data_i  = fwd_q[0];
        end
        if (!link.loc_valid_i && loc_q.size() > 0 && $urandom_range(99) < l_pct) begin
            link.loc_valid_i = 1'b1;
            link.loc_data_i  = loc_q[0];
        end
        link.link_ready_i = ($urandom_range(99) < r_pct);
        @(negedge clk_i);
        f_acc       = link.fwd_valid_i && link.fwd_ready_o;
        l_acc       = link.loc_valid_i && link.loc_ready_o;
        pop_s       = link.link_valid_o && link.link_ready_i;
        s_valid     = link.link_valid_o;
        s_fwd_ready = link.fwd_ready_o;
        s_data      = link.link_data_o;
        g_log.push_back(grant_o);
        v_log.push_back(link.link_valid_o);
        check("link_valid", link.link_valid_o, cnt_m > 0);
        check("one_ready", link.fwd_ready_o && link.loc_ready_o, 1'b0);
        if (cnt_m >= DEPTH) begin
            check("fwd_ready_full", link.fwd_ready_o, 1'b0);
            check("loc_ready_full", link.loc_ready_o, 1'b0);
        end
        if (cnt_m > 0 && !link.link_ready_i) ms++;
        if (pop_s) begin
            exp_head = (sb_q.size() > 0) ? sb_q[0] : 64'hDEAD_DEAD_DEAD_DEAD;
            check("link_data", link.link_data_o, exp_head);
            popped_q.push_back(link.link_data_o);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        if (f_acc) begin
            sb_q.push_back(link.fwd_data_i);
            void'(fwd_q.pop_front());
            mf++;
        end
        if (l_acc) begin
            sb_q.push_back(link.loc_data_i);
            void'(loc_q.pop_front());
            ml++;
        end
        cnt_m = cnt_m + int'(f_acc || l_acc) - int'(pop_s);
        // A waiting source may see at most MaxBurst beats of the other source go first.
        if (link.loc_valid_i && !l_acc) begin
            if (f_acc) w_loc++;
        end else w_loc = 0;
        if (link.fwd_valid_i && !f_acc) begin
            if (l_acc) w_fwd++;
        end else w_fwd = 0;
        check("loc_wait_bound", w_loc <= MB, 1'b1);
        check("fwd_wait_bound", w_fwd <= MB, 1'b1);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] stall_data;
        logic [63:0] beat;
        logic [7:0]  exp4 [11];
        int          refilled, nf, nl;

        // Reset state
        do_reset();
        check("rst_grant", grant_o, 2'b00);
        check("rst_link_valid", link.link_valid_o, 1'b0);
        check("rst_link_data", link.link_data_o, 64'h0);
        check("rst_fwd_ready", link.fwd_ready_o, 1'b0);
        check("rst_loc_ready", link.loc_ready_o, 1'b0);
        check("rst_stats", {fwd_beats_o | loc_beats_o | stall_cycles_o}, 32'h0);

        // Lone local stream of 10 beats
        for (int k = 0; k < 10; k++) loc_q.push_back({TAG_L, 24'h0, 32'(k)});
        repeat (14) cycle();
        check("t1_grant_idle", g_log[0], 2'b00);
        for (int c = 1; c <= 10; c++) check("t1_grant_loc", g_log[c], 2'b10);
        check("t1_valid_latency", v_log[1], 1'b0);
        for (int c = 2; c <= 11; c++) check("t1_valid_nogap", v_log[c], 1'b1);
        check("t1_count", popped_q.size(), 10);
        for (int k = 0; k < 10 && k < popped_q.size(); k++)
            check("t1_order", popped_q[k], {TAG_L, 24'h0, 32'(k)});

        // Both sources always valid: bursts of MaxBurst alternate
        do_reset();
        for (int k = 0; k < 12; k++) begin
            fwd_q.push_back({TAG_F, 24'h0, 32'(k)});
            loc_q.push_back({TAG_L, 24'h0, 32'(k)});
        end
        for (int c = 0; c < 80 && popped_q.size() < 24; c++) cycle();
        check("t2_count", popped_q.size(), 24);
        for (int c = 1; c <= 16; c++)
            check("t2_grant_alt", g_log[c], (((c - 1) / MB) % 2 == 0) ? 2'b01 : 2'b10);
        for (int i = 0; i < 24 && i < popped_q.size(); i++) begin
            beat = popped_q[i];
            check("t2_src_seq", beat[63:56], (((i / MB) % 2) == 0) ? TAG_F : TAG_L);
        end

        // Link back-pressure for 5 cycles while forward streams
        do_reset();
        for (int k = 0; k < 10; k++) fwd_q.push_back({TAG_F, 24'h0, 32'(k)});
        repeat (4) cycle();
        r_pct = 0;
        cycle();
        stall_data = s_data;
        check("t3_stall_valid", s_valid, 1'b1);
        repeat (4) begin
            cycle();
            check("t3_data_stable", s_data, stall_data);
            check("t3_fwd_ready_low", s_fwd_ready, 1'b0);
        end
        r_pct = 100;
        for (int c = 0; c < 60 && popped_q.size() < 10; c++) cycle();
        check("t3_count", popped_q.size(), 10);
        for (int k = 0; k < 10 && k < popped_q.size(); k++)
            check("t3_order", popped_q[k], {TAG_F, 24'h0, 32'(k)});
`ifdef RING_LINK_ARB_STATS_EN
        check("t3_stall_cycles", stall_cycles_o, 32'd5);
        check("t3_fwd_beats", fwd_beats_o, 32'd10);
`else
        check("t3_stall_cycles", stall_cycles_o, 32'd0);
        check("t3_fwd_beats", fwd_beats_o, 32'd0);
`endif

        // Forward runs dry: direct switch to local, which then keeps MaxBurst beats
        do_reset();
        for (int k = 0; k < 3; k++)  fwd_q.push_back({TAG_F, 24'h0, 32'(k)});
        for (int k = 0; k < 12; k++) loc_q.push_back({TAG_L, 24'h0, 32'(k)});
        refilled = 0;
        for (int c = 0; c < 80 && popped_q.size() < 11; c++) begin
            cycle();
            if (refilled == 0 && ml == 2) begin
                for (int k = 3; k < 9; k++) fwd_q.push_back({TAG_F, 24'h0, 32'(k)});
                refilled = 1;
            end
        end
        check("t4_count", popped_q.size(), 11);
        check("t4_grant_fwd_last", g_log[4], 2'b01);
        check("t4_grant_direct_loc", g_log[5], 2'b10);
        exp4 = '{TAG_F, TAG_F, TAG_F, TAG_L, TAG_L, TAG_L, TAG_L, TAG_F, TAG_F, TAG_F, TAG_F};
        for (int i = 0; i < 11 && i < popped_q.size(); i++) begin
            beat = popped_q[i];
            check("t4_src_seq", beat[63:56], exp4[i]);
        end

        // Reset while in LOC with two beats buffered
        do_reset();
        r_pct = 0;
        for (int k = 0; k < 5; k++) loc_q.push_back({TAG_L, 24'h0, 32'(k)});
        repeat (4) cycle();
        check("t5_pre_grant", grant_o, 2'b10);
        check("t5_pre_full", link.loc_ready_o, 1'b0);
        check("t5_pre_valid", link.link_valid_o, 1'b1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("t5_link_valid", link.link_valid_o, 1'b0);
        check("t5_grant", grant_o, 2'b00);
        check("t5_fwd_ready", link.fwd_ready_o, 1'b0);
        check("t5_loc_ready", link.loc_ready_o, 1'b0);
        check("t5_link_data", link.link_data_o, 64'h0);
        check("t5_stats", {fwd_beats_o | loc_beats_o | stall_cycles_o}, 32'h0);

        // Random traffic against the scoreboard
        do_reset();
        for (int k = 0; k < 150; k++) begin
            fwd_q.push_back({TAG_F, 24'($urandom), 32'(k)});
            loc_q.push_back({TAG_L, 24'($urandom), 32'(k)});
        end
        for (int ph = 0; ph < 3; ph++) begin
            f_pct = int'($urandom_range(90, 20));
            l_pct = int'($urandom_range(90, 20));
            r_pct = int'($urandom_range(90, 30));
            repeat (150) cycle();
        end
        f_pct = 100; l_pct = 100; r_pct = 100;
        for (int c = 0; c < 1000 && (fwd_q.size() + loc_q.size() + sb_q.size()) > 0; c++) cycle();
        check("t6_drained", fwd_q.size() + loc_q.size() + sb_q.size(), 0);
        check("t6_popped", popped_q.size(), 300);
        nf = 0; nl = 0;
        foreach (popped_q[i]) begin
            beat = popped_q[i];
            if (beat[63:56] == TAG_F) begin
                check("t6_fwd_order", beat[31:0], 32'(nf));
                nf++;
            end else begin
                check("t6_loc_order", beat[31:0], 32'(nl));
                nl++;
            end
        end
`ifdef RING_LINK_ARB_STATS_EN
        check("t6_fwd_beats", fwd_beats_o, 32'(mf));
        check("t6_loc_beats", loc_beats_o, 32'(ml));
        check("t6_stall_cycles", stall_cycles_o, 32'(ms));
`else
        check("t6_fwd_beats", fwd_beats_o, 32'd0);
        check("t6_loc_beats", loc_beats_o, 32'd0);
        check("t6_stall_cycles", stall_cycles_o, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
